// File: rtl/adc_lane_stats_cal_pkg.sv
// Shared constants, FSM state type and small arithmetic helpers for the
// per-lane ADC statistics / PFD-offset calibration engine.
package adc_lane_stats_cal_pkg;

  localparam int Nadc    = 8;          // ADC sample width (signed)
  localparam int Nrange  = 4;          // control field width
  localparam int Nsum    = 24;         // window accumulator width
  localparam int Nti     = 4;          // main lanes per dcore
  localparam int Nti_rep = 1;          // replica lanes per dcore
  localparam int Nhist   = 2**Nrange;  // histogram counter / output width
  localparam int Ncnt    = 16;         // sample counter width (window <= 2**15)

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_UPDATE = 1'b1
  } stats_state_t;

  localparam logic signed [Nadc-1:0] OFF_MIN = {1'b1, {(Nadc-1){1'b0}}};
  localparam logic signed [Nadc-1:0] OFF_MAX = {1'b0, {(Nadc-1){1'b1}}};

  // |a - b| computed one bit wider than the operands so it can never overflow.
  function automatic logic [Nadc:0] abs_diff(input logic signed [Nadc-1:0] a,
                                             input logic signed [Nadc-1:0] b);
    logic [Nadc:0] d;
    d = {a[Nadc-1], a} - {b[Nadc-1], b};
    if (d[Nadc]) begin
      return ({(Nadc+1){1'b0}} - d);
    end else begin
      return d;
    end
  endfunction

  // Window average: arithmetic shift (floor), keep the low Nadc bits.
  function automatic logic signed [Nadc-1:0] window_avg(input logic signed [Nsum-1:0] sum,
                                                         input logic [Nrange-1:0]     navg);
    logic signed [Nsum-1:0] sh;
    sh = sum >>> navg;
    return sh[Nadc-1:0];
  endfunction

  // One closed-loop calibration step: move the offset one code against the
  // average error, clamping at the signed range limits.
  function automatic logic signed [Nadc-1:0] cal_step(input logic signed [Nadc-1:0] off,
                                                       input logic signed [Nadc-1:0] avg,
                                                       input logic signed [Nadc-1:0] tgt);
    if ((avg > tgt) && (off != OFF_MIN)) begin
      return off - {{(Nadc-1){1'b0}}, 1'b1};
    end else if ((avg < tgt) && (off != OFF_MAX)) begin
      return off + {{(Nadc-1){1'b0}}, 1'b1};
    end else begin
      return off;
    end
  endfunction

endpackage

// File: rtl/adc_lane_stats_cal_if.sv
// Lane interface: sample stream and JTAG controls in, JTAG status out.
interface adc_lane_stats_cal_if;
  import adc_lane_stats_cal_pkg::*;

  logic signed [Nadc-1:0]   din;
  logic                     din_valid;
  logic [Nrange-1:0]        Navg;
  logic [Nrange-1:0]        Nbin;
  logic [Nrange-1:0]        DZ_hist;
  logic                     en_pfd_cal;
  logic                     en_ext_pfd_offset;
  logic [Nadc-1:0]          ext_pfd_offset;
  logic signed [Nadc-1:0]   pfd_cal_ext_ave;
  logic signed [Nadc-1:0]   adcout_avg;
  logic signed [Nsum-1:0]   adcout_sum;
  logic [Nhist-1:0]         adcout_hist_center;
  logic [Nhist-1:0]         adcout_hist_side;
  logic signed [Nadc-1:0]   pfd_offset;
  logic                     win_done;

  modport master (
    output din, din_valid, Navg, Nbin, DZ_hist, en_pfd_cal,
           en_ext_pfd_offset, ext_pfd_offset, pfd_cal_ext_ave,
    input  adcout_avg, adcout_sum, adcout_hist_center, adcout_hist_side,
           pfd_offset, win_done
  );

  modport slave (
    input  din, din_valid, Navg, Nbin, DZ_hist, en_pfd_cal,
           en_ext_pfd_offset, ext_pfd_offset, pfd_cal_ext_ave,
    output adcout_avg, adcout_sum, adcout_hist_center, adcout_hist_side,
           pfd_offset, win_done
  );

endinterface

// File: rtl/adc_lane_stats_cal_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module adc_lane_stats_cal_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_lane_stats_cal.sv
// Per-lane ADC window statistics (sum, average, two-bin histogram) and
// PFD offset calibration. Accumulates 2**Navg valid samples, then spends one
// UPDATE cycle publishing the results and stepping the offset.
module adc_lane_stats_cal
  import adc_lane_stats_cal_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  adc_lane_stats_cal_if.slave lane
);

  stats_state_t           state_q, state_d;
  logic signed [Nsum-1:0] acc_q, acc_d;
  logic [Ncnt-1:0]        cnt_q, cnt_d;
  logic signed [Nsum-1:0] sum_q, sum_d;
  logic signed [Nadc-1:0] avg_q, avg_d;
  logic [Nhist-1:0]       hc_q, hc_d;
  logic [Nhist-1:0]       hs_q, hs_d;
  logic signed [Nadc-1:0] off_q, off_d;
  logic                   wd_q, wd_d;

  logic [Ncnt-1:0]        win_last_s;
  logic                   win_end_s;
  logic                   accum_s;
  logic [Nadc:0]          abs_s;
  logic [Nadc:0]          dz_s;
  logic [Nadc:0]          side_hi_s;
  logic                   inc_c_s;
  logic                   inc_s_s;
  logic                   clr_ctr_s;
  logic [Nhist-1:0]       ctr_c_s;
  logic [Nhist-1:0]       ctr_s_s;
  logic signed [Nadc-1:0] avg_new_s;
  logic signed [Nsum-1:0] din_ext_s;

  // Window length follows the live Navg, so a shrink mid-window closes early.
  assign win_last_s = (16'd1 << lane.Navg) - 16'd1;
  assign accum_s    = (state_q == ST_ACCUM) && lane.din_valid;
  assign win_end_s  = accum_s && (cnt_q >= win_last_s);
  assign din_ext_s  = {{(Nsum-Nadc){lane.din[Nadc-1]}}, lane.din};

  // Histogram classification against the offset-corrected sample.
  assign abs_s      = abs_diff(lane.din, off_q);
  assign dz_s       = {{(Nadc+1-Nrange){1'b0}}, lane.DZ_hist};
  assign side_hi_s  = dz_s + {{(Nadc+1-Nrange){1'b0}}, lane.Nbin};
  assign inc_c_s    = accum_s && (abs_s <= dz_s);
  assign inc_s_s    = accum_s && (abs_s > dz_s) && (abs_s <= side_hi_s);
  assign clr_ctr_s  = (state_q == ST_UPDATE);
  assign avg_new_s  = window_avg(acc_q, lane.Navg);

  adc_lane_stats_cal_sat_counter #(.W(Nhist)) u_ctr_c (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_ctr_s),
    .inc_i (inc_c_s),
    .cnt_o (ctr_c_s)
  );

  adc_lane_stats_cal_sat_counter #(.W(Nhist)) u_ctr_s (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_ctr_s),
    .inc_i (inc_s_s),
    .cnt_o (ctr_s_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave ACCUM on the closing sample, UPDATE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (win_end_s) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_UPDATE: state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  // Datapath next values: accumulate in ACCUM, publish and clear in UPDATE.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    avg_d = avg_q;
    hc_d  = hc_q;
    hs_d  = hs_q;
    wd_d  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (lane.din_valid) begin
          acc_d = acc_q + din_ext_s;
          cnt_d = cnt_q + 16'd1;
        end else begin
          acc_d = acc_q;
          cnt_d = cnt_q;
        end
      end
      ST_UPDATE: begin
        sum_d = acc_q;
        avg_d = avg_new_s;
        hc_d  = ctr_c_s;
        hs_d  = ctr_s_s;
        wd_d  = 1'b1;
        acc_d = {Nsum{1'b0}};
        cnt_d = {Ncnt{1'b0}};
      end
      default: begin
        acc_d = {Nsum{1'b0}};
        cnt_d = {Ncnt{1'b0}};
      end
    endcase
  end

  // Offset: external force every cycle, else one calibration step per UPDATE.
  always_comb begin
    off_d = off_q;
    if (lane.en_ext_pfd_offset) begin
      off_d = $signed(lane.ext_pfd_offset);
    end else if (lane.en_pfd_cal && (state_q == ST_UPDATE)) begin
      off_d = cal_step(off_q, avg_new_s, lane.pfd_cal_ext_ave);
    end else begin
      off_d = off_q;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {Nsum{1'b0}};
      cnt_q <= {Ncnt{1'b0}};
      sum_q <= {Nsum{1'b0}};
      avg_q <= {Nadc{1'b0}};
      hc_q  <= {Nhist{1'b0}};
      hs_q  <= {Nhist{1'b0}};
      off_q <= {Nadc{1'b0}};
      wd_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      avg_q <= avg_d;
      hc_q  <= hc_d;
      hs_q  <= hs_d;
      off_q <= off_d;
      wd_q  <= wd_d;
    end
  end

  assign lane.adcout_sum         = sum_q;
  assign lane.adcout_avg         = avg_q;
  assign lane.adcout_hist_center = hc_q;
  assign lane.adcout_hist_side   = hs_q;
  assign lane.pfd_offset         = off_q;
  assign lane.win_done           = wd_q;

endmodule

// File: tb/tb_adc_lane_stats_cal.sv
// Bench for adc_lane_stats_cal: directed steps plus random traffic, every
// cycle compared against a sample-list reference model.
module tb_adc_lane_stats_cal;
  import adc_lane_stats_cal_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_lane_stats_cal_if lane_if ();

  adc_lane_stats_cal dut (
    .clk  (clk),
    .rst  (rst),
    .lane (lane_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dut_wd  = 0;

  // Reference model: window contents as plain integers.
  int m_sum, m_cnt, m_c, m_s, m_off;
  bit m_upd;
  int e_sum, e_avg, e_hc, e_hs;
  bit e_wd;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int wrap8(input int x);
    logic [7:0] b;
    b = x[7:0];
    return int'($signed(b));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_edge();
    int d, a, w, tgt;
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_c = 0; m_s = 0; m_off = 0; m_upd = 0;
      e_sum = 0; e_avg = 0; e_hc = 0; e_hs = 0; e_wd = 0;
    end else begin
      e_wd = 0;
      if (m_upd) begin
        e_sum = m_sum;
        e_avg = wrap8(floor_div(m_sum, 1 << lane_if.Navg));
        e_hc  = m_c;
        e_hs  = m_s;
        e_wd  = 1;
        m_sum = 0; m_cnt = 0; m_c = 0; m_s = 0; m_upd = 0;
        if (!lane_if.en_ext_pfd_offset && lane_if.en_pfd_cal) begin
          tgt = int'(lane_if.pfd_cal_ext_ave);
          if (e_avg > tgt && m_off > -128) m_off = m_off - 1;
          else if (e_avg < tgt && m_off < 127) m_off = m_off + 1;
        end
      end else if (lane_if.din_valid) begin
        d = int'(lane_if.din);
        m_sum = m_sum + d;
        m_cnt = m_cnt + 1;
        a = d - m_off;
        if (a < 0) a = -a;
        w = int'(lane_if.DZ_hist);
        if (a <= w) begin
          if (m_c < 65535) m_c = m_c + 1;
        end else if (a <= w + int'(lane_if.Nbin)) begin
          if (m_s < 65535) m_s = m_s + 1;
        end
        if (m_cnt >= (1 << lane_if.Navg)) m_upd = 1;
      end
      if (lane_if.en_ext_pfd_offset) m_off = wrap8(int'(lane_if.ext_pfd_offset));
    end
  endtask

  task automatic check_all();
    if (lane_if.win_done === 1'b1) dut_wd++;
    chk("win_done",    {31'd0, lane_if.win_done}, {31'd0, e_wd});
    chk("adcout_sum",  lane_if.adcout_sum, e_sum);
    chk("adcout_avg",  lane_if.adcout_avg, e_avg);
    chk("hist_center", lane_if.adcout_hist_center, e_hc);
    chk("hist_side",   lane_if.adcout_hist_side, e_hs);
    chk("pfd_offset",  lane_if.pfd_offset, m_off);
  endtask

  // One clock: apply inputs, let the edge happen, update model, compare.
  task automatic step(input bit v, input int d);
    lane_if.din       = d[7:0];
    lane_if.din_valid = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int wd0;
    rst = 1'b1;
    lane_if.din = 8'd0;
    lane_if.din_valid = 1'b0;
    lane_if.Navg = 4'd3;
    lane_if.Nbin = 4'd0;
    lane_if.DZ_hist = 4'd0;
    lane_if.en_pfd_cal = 1'b0;
    lane_if.en_ext_pfd_offset = 1'b0;
    lane_if.ext_pfd_offset = 8'd0;
    lane_if.pfd_cal_ext_ave = 8'sd0;
    step(1'b0, 0);
    step(1'b0, 0);
    rst = 1'b0;

    // Navg=3, eight samples of +5
    wd0 = dut_wd;
    for (int i = 0; i < 8; i++) step(1'b1, 5);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("t2_sum", lane_if.adcout_sum, 40);
    chk("t2_avg", lane_if.adcout_avg, 5);
    chk("t2_wd_once", dut_wd - wd0, 1);

    // reset mid-window, then a fresh window of +2
    for (int i = 0; i < 3; i++) step(1'b1, 9);
    rst = 1'b1;
    step(1'b1, 9);
    step(1'b1, 9);
    chk("t1_rst_sum", lane_if.adcout_sum, 0);
    chk("t1_rst_wd", {31'd0, lane_if.win_done}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 2);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("t1_fresh_sum", lane_if.adcout_sum, 16);

    // histogram bins
    lane_if.Navg = 4'd2; lane_if.DZ_hist = 4'd1; lane_if.Nbin = 4'd2;
    step(1'b1, 0); step(1'b1, -1); step(1'b1, 3); step(1'b1, 5);
    step(1'b0, 0); step(1'b0, 0);
    chk("t3_center", lane_if.adcout_hist_center, 2);
    chk("t3_side", lane_if.adcout_hist_side, 1);

    // floor average of a negative sum
    lane_if.Navg = 4'd1;
    step(1'b1, -3); step(1'b1, -4);
    step(1'b0, 0); step(1'b0, 0);
    chk("t4_sum", lane_if.adcout_sum, -7);
    chk("t4_avg", lane_if.adcout_avg, -4);

    // random traffic with control changes mid-window
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) lane_if.Navg = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) lane_if.DZ_hist = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lane_if.Nbin = 4'($urandom_range(0, 15));
      lane_if.en_ext_pfd_offset = ($urandom_range(0, 19) == 0);
      lane_if.ext_pfd_offset = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) lane_if.en_pfd_cal = ~lane_if.en_pfd_cal;
      lane_if.pfd_cal_ext_ave = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
    end
    lane_if.en_ext_pfd_offset = 1'b0;

    // closed-loop calibration up to the positive limit, then ext override
    lane_if.en_pfd_cal = 1'b1;
    lane_if.pfd_cal_ext_ave = 8'sd0;
    lane_if.Navg = 4'd0;
    for (int i = 0; i < 600; i++) step(1'b1, -10);
    chk("t5_sat_hi", lane_if.pfd_offset, 127);
    for (int i = 0; i < 10; i++) step(1'b1, 10);
    chk("t5_step_dn", lane_if.pfd_offset, 122);
    lane_if.en_ext_pfd_offset = 1'b1;
    lane_if.ext_pfd_offset = 8'hF0;
    step(1'b0, 0);
    chk("t5_ext", lane_if.pfd_offset, -16);
    lane_if.en_pfd_cal = 1'b0;
    step(1'b0, 0);
    lane_if.en_ext_pfd_offset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 10);
    chk("t5_hold", lane_if.pfd_offset, -16);

    // maximum window of the most negative code
    lane_if.en_ext_pfd_offset = 1'b1;
    lane_if.ext_pfd_offset = 8'h00;
    step(1'b0, 0);
    step(1'b0, 0);
    lane_if.en_ext_pfd_offset = 1'b0;
    lane_if.Navg = 4'd15;
    for (int i = 0; i < 32768; i++) step(1'b1, -128);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("t6_sum", lane_if.adcout_sum, -4194304);
    chk("t6_avg", lane_if.adcout_avg, -128);

    // shrink Navg after five samples: the next valid sample closes the window
    lane_if.Navg = 4'd4;
    for (int i = 0; i < 5; i++) step(1'b1, 7);
    lane_if.Navg = 4'd2;
    wd0 = dut_wd;
    step(1'b1, 7);
    step(1'b0, 0);
    chk("t6_shrink_wd", dut_wd - wd0, 1);
    chk("t6_shrink_sum", lane_if.adcout_sum, 42);
    chk("t6_shrink_avg", lane_if.adcout_avg, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
